// File: rtl/lc3_mem_responder.sv
// lc3_mem_responder: LC-3 MAR/MDR memory responder with wait states and memory-mapped switch/hex I/O
// Optional address range checking with ERR output is enabled by defining LC3_MEM_ADDR_CHECK_EN.
module lc3_mem_responder #(
  parameter int          MEM_DEPTH   = 256,
  parameter int          WAIT_STATES = 2,
  parameter logic [15:0] IO_ADDR     = 16'hFFFF
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        MEM_EN,
  input  logic        WE,
  input  logic [15:0] ADDR,
  input  logic [15:0] DATA_IN,
  input  logic [15:0] SW,
  output logic [15:0] DATA_OUT,
  output logic        R,
  output logic [15:0] HEX_OUT
`ifdef LC3_MEM_ADDR_CHECK_EN
  ,
  output logic        ERR
`endif
);
  localparam int AW = $clog2(MEM_DEPTH);
  typedef enum logic [1:0] {IDLE, WAIT, DONE, HOLD} state_t;
  state_t      state;
  logic [3:0]  cnt;
  logic [15:0] addr_q, din_q;
  logic        we_q, io, oor;
  logic [15:0] ram [MEM_DEPTH];
  assign io = addr_q == IO_ADDR;
`ifdef LC3_MEM_ADDR_CHECK_EN
  assign oor = !io && ((addr_q >> AW) != 16'd0);
`else
  assign oor = 1'b0;
`endif
  // R and read data register on the edge leaving DONE, so both appear together one cycle later
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      addr_q   <= 16'd0;
      din_q    <= 16'd0;
      we_q     <= 1'b0;
      DATA_OUT <= 16'd0;
      R        <= 1'b0;
      HEX_OUT  <= 16'd0;
`ifdef LC3_MEM_ADDR_CHECK_EN
      ERR      <= 1'b0;
`endif
    end else begin
      R <= 1'b0;
`ifdef LC3_MEM_ADDR_CHECK_EN
      ERR <= 1'b0;
`endif
      case (state)
        IDLE: if (MEM_EN) begin
          addr_q <= ADDR;
          we_q   <= WE;
          din_q  <= DATA_IN;
          cnt    <= 4'(WAIT_STATES);
          state  <= (WAIT_STATES == 0) ? DONE : WAIT;
        end
        WAIT: begin
          cnt   <= cnt - 4'd1;
          state <= (cnt == 4'd1) ? DONE : WAIT;
        end
        DONE: begin
          R     <= 1'b1;
          state <= HOLD;
`ifdef LC3_MEM_ADDR_CHECK_EN
          ERR   <= oor;
`endif
          if (!we_q)
            DATA_OUT <= io ? SW : oor ? 16'd0 : ram[addr_q[AW-1:0]];
          else if (io)
            HEX_OUT <= din_q;
        end
        HOLD: state <= MEM_EN ? HOLD : IDLE;
        default: state <= IDLE;
      endcase
    end
  end
  always_ff @(posedge Clk)
    if (state == DONE && we_q && !io && !oor) ram[addr_q[AW-1:0]] <= din_q;
endmodule

// File: tb/tb_lc3_mem_responder.sv
// tb_lc3_mem_responder: directed checks of latency, RAM/I/O access, hold handshake and reset abort
module tb_lc3_mem_responder;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        en0 = 1'b0, we0 = 1'b0, en1 = 1'b0, we1 = 1'b0;
  logic [15:0] addr0 = '0, din0 = '0, addr1 = '0, din1 = '0, sw = '0;
  logic [15:0] dout0, dout1, hex0, hex1;
  logic        r0, r1, err0, err1;
  int          errors = 0, checks = 0, lat, cnt;
  logic        e_seen;

  always #5 clk = ~clk;

  lc3_mem_responder #(.MEM_DEPTH(256), .WAIT_STATES(2), .IO_ADDR(16'hFFFF)) u0 (
    .Clk(clk), .Reset_n(rst_n), .MEM_EN(en0), .WE(we0), .ADDR(addr0), .DATA_IN(din0),
    .SW(sw), .DATA_OUT(dout0), .R(r0), .HEX_OUT(hex0)
`ifdef LC3_MEM_ADDR_CHECK_EN
    , .ERR(err0)
`endif
  );
  lc3_mem_responder #(.MEM_DEPTH(256), .WAIT_STATES(0), .IO_ADDR(16'hFFFF)) u1 (
    .Clk(clk), .Reset_n(rst_n), .MEM_EN(en1), .WE(we1), .ADDR(addr1), .DATA_IN(din1),
    .SW(sw), .DATA_OUT(dout1), .R(r1), .HEX_OUT(hex1)
`ifdef LC3_MEM_ADDR_CHECK_EN
    , .ERR(err1)
`endif
  );
`ifndef LC3_MEM_ADDR_CHECK_EN
  assign err0 = 1'b0;
  assign err1 = 1'b0;
`endif

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // one access on u0 (s=0) or u1 (s=1); lat = negedges from request to R, 0 on timeout
  task automatic acc(input bit s, input logic w, input logic [15:0] a, input logic [15:0] d,
                     input bit chg, output int l, output logic e);
    if (s) begin en1 = 1; we1 = w; addr1 = a; din1 = d; end
    else begin en0 = 1; we0 = w; addr0 = a; din0 = d; end
    l = 0;
    e = 1'b0;
    for (int n = 1; n <= 20 && l == 0; n++) begin
      @(negedge clk);
      if (chg && n == 1) begin
        if (s) addr1 = a + 16'd1; else addr0 = a + 16'd1;
      end
      if ((s ? r1 : r0) === 1'b1) begin
        l = n;
        e = s ? err1 : err0;
      end
    end
    if (s) en1 = 0; else en0 = 0;
    @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_dout", dout0, 16'h0000);
    chk("rst_r", {15'd0, r0}, 16'h0000);
    chk("rst_hex", hex0, 16'h0000);
    rst_n = 1'b1;
    @(negedge clk);

    acc(0, 1, 16'h0010, 16'h1234, 0, lat, e_seen);
    chk("wr_lat", 16'(lat), 16'd4);
    chk("wr_dout_unchanged", dout0, 16'h0000);
    acc(0, 0, 16'h0010, 16'h0000, 0, lat, e_seen);
    chk("rd_lat", 16'(lat), 16'd4);
    chk("rd_data", dout0, 16'h1234);

    acc(0, 1, 16'hFFFF, 16'hBEEF, 0, lat, e_seen);
    chk("io_wr_lat", 16'(lat), 16'd4);
    chk("io_hex", hex0, 16'hBEEF);
    chk("io_wr_dout_unchanged", dout0, 16'h1234);
    sw = 16'h00A5;
    acc(0, 0, 16'hFFFF, 16'h0000, 0, lat, e_seen);
    chk("io_rd_data", dout0, 16'h00A5);

`ifdef LC3_MEM_ADDR_CHECK_EN
    acc(0, 1, 16'h0000, 16'h1111, 0, lat, e_seen);
    acc(0, 0, 16'h0100, 16'h0000, 0, lat, e_seen);
    chk("oor_rd_data", dout0, 16'h0000);
    chk("oor_err", {15'd0, e_seen}, 16'h0001);
    chk("oor_lat", 16'(lat), 16'd4);
    acc(0, 1, 16'h0100, 16'hABCD, 0, lat, e_seen);
    acc(0, 0, 16'h0000, 16'h0000, 0, lat, e_seen);
    chk("oor_wr_discard", dout0, 16'h1111);
    chk("inrange_err", {15'd0, e_seen}, 16'h0000);
`else
    acc(0, 1, 16'h0105, 16'h7777, 0, lat, e_seen);
    acc(0, 0, 16'h0005, 16'h0000, 0, lat, e_seen);
    chk("alias_rd", dout0, 16'h7777);
`endif

    en0 = 1; we0 = 0; addr0 = 16'h0010;
    cnt = 0;
    repeat (20) begin @(negedge clk); if (r0) cnt++; end
    chk("held_one_pulse", 16'(cnt), 16'd1);
    en0 = 0;
    @(negedge clk);
    en0 = 1;
    cnt = 0;
    repeat (10) begin @(negedge clk); if (r0) cnt++; end
    chk("rearm_one_pulse", 16'(cnt), 16'd1);
    en0 = 0;
    @(negedge clk);

    acc(0, 1, 16'h0020, 16'h2222, 0, lat, e_seen);
    en0 = 1; we0 = 1; addr0 = 16'h0020; din0 = 16'hFFFF;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    cnt = 0;
    @(negedge clk);
    if (r0) cnt++;
    rst_n = 1'b1;
    en0 = 0;
    repeat (6) begin @(negedge clk); if (r0) cnt++; end
    chk("abort_no_r", 16'(cnt), 16'd0);
    chk("abort_hex_reset", hex0, 16'h0000);
    acc(0, 0, 16'h0020, 16'h0000, 0, lat, e_seen);
    chk("abort_no_write", dout0, 16'h2222);

    acc(1, 1, 16'h0030, 16'h4321, 0, lat, e_seen);
    chk("zw_wr_lat", 16'(lat), 16'd2);
    acc(1, 1, 16'h0031, 16'h9999, 0, lat, e_seen);
    acc(1, 0, 16'h0030, 16'h0000, 1, lat, e_seen);
    chk("zw_rd_lat", 16'(lat), 16'd2);
    chk("zw_addr_latched", dout1, 16'h4321);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
